// File: rtl/branch_fetch_control_if.sv
// branch_fetch_control_if
//   Groups the fetch-side and execute-side signals of the branch fetch
//   controller.
//   Fetch side : stall_F, opcode_F, imm_F, prediction -> Pc_F, GHR_f
//   Execute    : resolve_E, actual_taken_E, pred_taken_E, pc_E, imm_E, ghr_E
//   Control out: flush_FD, branch_cnt, mispred_cnt
//   Modports   : slave  = the controller (consumes inputs, drives outputs)
//                master = the pipeline around it (drives inputs)
//   Handshake: resolve_E is a single-cycle valid strobe with no ready side.
//   It qualifies actual_taken_E, pred_taken_E, pc_E, imm_E and ghr_E in the
//   same cycle, and the controller always accepts it.
interface branch_fetch_control_if #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
);
  logic             stall_F;
  logic [5:0]       opcode_F;
  logic [PC_W-1:0]  imm_F;
  logic             prediction;
  logic             resolve_E;
  logic             actual_taken_E;
  logic             pred_taken_E;
  logic [PC_W-1:0]  pc_E;
  logic [PC_W-1:0]  imm_E;
  logic [3:0]       ghr_E;
  logic [PC_W-1:0]  Pc_F;
  logic [3:0]       GHR_f;
  logic             flush_FD;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport slave (
    input  stall_F, opcode_F, imm_F, prediction,
    input  resolve_E, actual_taken_E, pred_taken_E, pc_E, imm_E, ghr_E,
    output Pc_F, GHR_f, flush_FD, branch_cnt, mispred_cnt
  );

  modport master (
    output stall_F, opcode_F, imm_F, prediction,
    output resolve_E, actual_taken_E, pred_taken_E, pc_E, imm_E, ghr_E,
    input  Pc_F, GHR_f, flush_FD, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_fetch_control.sv
// branch_fetch_control
//   Owns the fetch PC and the speculative 4-bit global history register.
//   Each cycle it picks the next PC and the next GHR. In priority order the
//   choices are: a redirect from a branch that resolved as mispredicted in
//   Execute, a fetch stall, a predicted-taken beq/bne in Fetch, or a
//   sequential fetch. It also counts resolved and mispredicted branches with
//   counters that saturate at all-ones.
// Ports
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-low
//   bus   : branch_fetch_control_if.slave (see interface for signal list)
module branch_fetch_control #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  branch_fetch_control_if.slave   bus
);

  localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             is_br_f;
  logic             pred_f;
  logic             mispredict;
  logic [PC_W-1:0]  pc_q,  pc_d;
  logic [3:0]       ghr_q, ghr_d;
  logic [CNT_W-1:0] branch_cnt_q, mispred_cnt_q;

  assign is_br_f    = (bus.opcode_F == 6'd4) || (bus.opcode_F == 6'd5);
  assign pred_f     = bus.prediction && is_br_f;
  assign mispredict = bus.resolve_E && (bus.actual_taken_E != bus.pred_taken_E);

  // Next fetch PC and history. A mispredict wins over a stall: the wrong-path
  // instructions being held are flushed anyway. PC sums wrap silently at
  // PC_W bits. A correctly predicted resolve leaves PC and GHR alone.
  always_comb begin
    pc_d  = pc_q;
    ghr_d = ghr_q;
    if (mispredict) begin
      // Rebuild history from the snapshot taken when the branch was fetched.
      pc_d  = bus.actual_taken_E ? (bus.pc_E + PC_ONE + bus.imm_E)
                                 : (bus.pc_E + PC_ONE);
      ghr_d = {bus.ghr_E[2:0], bus.actual_taken_E};
    end else if (bus.stall_F) begin
      pc_d  = pc_q;
      ghr_d = ghr_q;
    end else begin
      pc_d = pred_f ? (pc_q + PC_ONE + bus.imm_F) : (pc_q + PC_ONE);
      // Only branches shift the history; other instructions leave it as is.
      if (is_br_f) begin
        ghr_d = {ghr_q[2:0], pred_f};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= '0;
      ghr_q <= '0;
    end else begin
      pc_q  <= pc_d;
      ghr_q <= ghr_d;
    end
  end

  // Performance counters ignore stall_F and hold once they reach all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (bus.resolve_E && (branch_cnt_q != CNT_MAX)) begin
        branch_cnt_q <= branch_cnt_q + CNT_ONE;
      end
      if (mispredict && (mispred_cnt_q != CNT_MAX)) begin
        mispred_cnt_q <= mispred_cnt_q + CNT_ONE;
      end
    end
  end

  assign bus.Pc_F        = pc_q;
  assign bus.GHR_f       = ghr_q;
  assign bus.flush_FD    = mispredict;
  assign bus.branch_cnt  = branch_cnt_q;
  assign bus.mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_fetch_control.sv
module tb_branch_fetch_control;

  localparam int PC_W  = 8;
  localparam int CNT_W = 16;
  localparam int EW    = 1 + PC_W + 4 + 2 * CNT_W;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  branch_fetch_control_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  branch_fetch_control #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  // Each entry is {flush, pc, ghr, branch_cnt, mispred_cnt} expected after
  // the cycle that pushed it (flush is the same-cycle value).
  logic [EW-1:0]    exp_q[$];
  int               n_cmp;
  int               n_fail;

  logic [PC_W-1:0]  m_pc;
  logic [3:0]       m_ghr;
  logic [CNT_W-1:0] m_bc;
  logic [CNT_W-1:0] m_mc;
  logic             obs_flush;

  logic [EW-1:0]    e;
  logic             e_fl;
  logic [PC_W-1:0]  e_pc;
  logic [3:0]       e_ghr;
  logic [CNT_W-1:0] e_bc;
  logic [CNT_W-1:0] e_mc;

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.stall_F        = 1'b0;
    bus.opcode_F       = 6'd0;
    bus.imm_F          = '0;
    bus.prediction     = 1'b0;
    bus.resolve_E      = 1'b0;
    bus.actual_taken_E = 1'b0;
    bus.pred_taken_E   = 1'b0;
    bus.pc_E           = '0;
    bus.imm_E          = '0;
    bus.ghr_E          = '0;
  endtask

  task automatic model_reset();
    m_pc  = '0;
    m_ghr = '0;
    m_bc  = '0;
    m_mc  = '0;
  endtask

  // Drives one cycle of stimulus, pushes the reference expectation, captures
  // flush before the edge and returns 1 time unit after the edge.
  task automatic drive(input logic st, input logic [5:0] opc,
                       input logic [PC_W-1:0] imm, input logic pr,
                       input logic res, input logic act, input logic pt,
                       input logic [PC_W-1:0] pce, input logic [PC_W-1:0] ime,
                       input logic [3:0] ghe);
    logic            mis;
    logic            br;
    logic [PC_W-1:0] npc;
    logic [3:0]      nghr;
    bus.stall_F        = st;
    bus.opcode_F       = opc;
    bus.imm_F          = imm;
    bus.prediction     = pr;
    bus.resolve_E      = res;
    bus.actual_taken_E = act;
    bus.pred_taken_E   = pt;
    bus.pc_E           = pce;
    bus.imm_E          = ime;
    bus.ghr_E          = ghe;
    mis  = res && (act != pt);
    br   = (opc == 6'd4) || (opc == 6'd5);
    npc  = m_pc;
    nghr = m_ghr;
    if (mis) begin
      npc  = act ? PC_W'(pce + ime + PC_W'(1)) : PC_W'(pce + PC_W'(1));
      nghr = {ghe[2:0], act};
    end else if (!st) begin
      npc = (pr && br) ? PC_W'(m_pc + imm + PC_W'(1)) : PC_W'(m_pc + PC_W'(1));
      if (br) nghr = {m_ghr[2:0], pr};
    end
    if (res && m_bc != {CNT_W{1'b1}}) m_bc = m_bc + 1'b1;
    if (mis && m_mc != {CNT_W{1'b1}}) m_mc = m_mc + 1'b1;
    m_pc  = npc;
    m_ghr = nghr;
    exp_q.push_back({mis, m_pc, m_ghr, m_bc, m_mc});
    #1;
    obs_flush = bus.flush_FD;
    @(posedge clk);
    #1;
  endtask

  task automatic pop_exp();
    e = exp_q.pop_front();
    {e_fl, e_pc, e_ghr, e_bc, e_mc} = e;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    model_reset();
    #12;
    bus.resolve_E = 1'b1; bus.actual_taken_E = 1'b1; bus.pred_taken_E = 1'b0;
    #1;
    n_cmp++; if (bus.Pc_F !== 8'h00) begin n_fail++; $display("FAIL rst_pc: got %h expected 00", bus.Pc_F); end
    n_cmp++; if (bus.GHR_f !== 4'h0) begin n_fail++; $display("FAIL rst_ghr: got %h expected 0", bus.GHR_f); end
    n_cmp++; if (bus.branch_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_bc: got %h expected 0", bus.branch_cnt); end
    n_cmp++; if (bus.mispred_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_mc: got %h expected 0", bus.mispred_cnt); end
    n_cmp++; if (bus.flush_FD !== 1'b1) begin n_fail++; $display("FAIL rst_flush_follows: got %b expected 1", bus.flush_FD); end
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_sequential();
    // First fetch after release is from Pc_F = 0 (one edge has passed in
    // reset-released state? no: release was at negedge, one edge with idle
    // inputs advanced the model below).
    n_cmp++; if (bus.Pc_F !== 8'h01) begin n_fail++; $display("FAIL seq_first: got %h expected 01", bus.Pc_F); end
    m_pc = 8'h01;
    for (int i = 2; i <= 4; i++) begin
      drive(0, 6'd0, '0, 0, 0, 0, 0, '0, '0, '0);
      pop_exp();
      n_cmp++; if (bus.Pc_F !== e_pc || bus.Pc_F !== PC_W'(i)) begin n_fail++; $display("FAIL seq_pc: got %h expected %h", bus.Pc_F, e_pc); end
      n_cmp++; if (bus.GHR_f !== 4'h0) begin n_fail++; $display("FAIL seq_ghr: got %h expected 0", bus.GHR_f); end
    end
    while (m_pc != 8'h10) begin
      drive(0, 6'd0, '0, 1, 0, 0, 0, '0, '0, '0);
      pop_exp();
    end
    n_cmp++; if (bus.Pc_F !== 8'h10) begin n_fail++; $display("FAIL seq_reach10: got %h expected 10", bus.Pc_F); end
  endtask

  task automatic test_predicted_branch();
    drive(0, 6'd4, 8'h05, 1, 0, 0, 0, '0, '0, '0);
    pop_exp();
    n_cmp++; if (bus.Pc_F !== 8'h16) begin n_fail++; $display("FAIL pbr_pc: got %h expected 16", bus.Pc_F); end
    n_cmp++; if (bus.GHR_f !== 4'b0001) begin n_fail++; $display("FAIL pbr_ghr: got %b expected 0001", bus.GHR_f); end
    // bne predicted not taken: sequential, history shifts in a 0.
    drive(0, 6'd5, 8'h40, 0, 0, 0, 0, '0, '0, '0);
    pop_exp();
    n_cmp++; if (bus.Pc_F !== 8'h17 || bus.Pc_F !== e_pc) begin n_fail++; $display("FAIL bne_nt_pc: got %h expected %h", bus.Pc_F, e_pc); end
    n_cmp++; if (bus.GHR_f !== 4'b0010) begin n_fail++; $display("FAIL bne_nt_ghr: got %b expected 0010", bus.GHR_f); end
    // Non-branch with prediction high: ignored, history held.
    drive(0, 6'd6, 8'h40, 1, 0, 0, 0, '0, '0, '0);
    pop_exp();
    n_cmp++; if (bus.Pc_F !== 8'h18) begin n_fail++; $display("FAIL nonbr_pc: got %h expected 18", bus.Pc_F); end
    n_cmp++; if (bus.GHR_f !== 4'b0010) begin n_fail++; $display("FAIL nonbr_ghr: got %b expected 0010", bus.GHR_f); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      drive(1, 6'd4, 8'h22, 1, 0, 0, 0, '0, '0, '0);
      pop_exp();
      n_cmp++; if (bus.Pc_F !== 8'h18 || bus.GHR_f !== 4'b0010) begin n_fail++; $display("FAIL stall_hold: got pc %h ghr %b expected 18 0010", bus.Pc_F, bus.GHR_f); end
    end
  endtask

  task automatic test_mispredict_stall();
    logic [CNT_W-1:0] mc0;
    mc0 = bus.mispred_cnt;
    drive(1, 6'd4, 8'h05, 1, 1, 0, 1, 8'h20, 8'h33, 4'b0101);
    pop_exp();
    n_cmp++; if (obs_flush !== 1'b1) begin n_fail++; $display("FAIL mis_flush: got %b expected 1", obs_flush); end
    n_cmp++; if (bus.Pc_F !== 8'h21) begin n_fail++; $display("FAIL mis_pc: got %h expected 21", bus.Pc_F); end
    n_cmp++; if (bus.GHR_f !== 4'b1010) begin n_fail++; $display("FAIL mis_ghr: got %b expected 1010", bus.GHR_f); end
    n_cmp++; if (bus.mispred_cnt !== mc0 + 1'b1 || bus.mispred_cnt !== e_mc) begin n_fail++; $display("FAIL mis_cnt: got %h expected %h", bus.mispred_cnt, e_mc); end
    // Taken-but-predicted-not-taken redirect to pc_E+1+imm_E.
    drive(0, 6'd0, '0, 0, 1, 1, 0, 8'h30, 8'h10, 4'b0011);
    pop_exp();
    n_cmp++; if (obs_flush !== 1'b1) begin n_fail++; $display("FAIL mis_t_flush: got %b expected 1", obs_flush); end
    n_cmp++; if (bus.Pc_F !== 8'h41) begin n_fail++; $display("FAIL mis_t_pc: got %h expected 41", bus.Pc_F); end
    n_cmp++; if (bus.GHR_f !== 4'b0111) begin n_fail++; $display("FAIL mis_t_ghr: got %b expected 0111", bus.GHR_f); end
  endtask

  task automatic test_correct_resolve();
    drive(0, 6'd0, '0, 0, 1, 1, 1, 8'h77, 8'h05, 4'b1111);
    pop_exp();
    n_cmp++; if (obs_flush !== 1'b0) begin n_fail++; $display("FAIL ok_flush: got %b expected 0", obs_flush); end
    n_cmp++; if (bus.Pc_F !== 8'h42) begin n_fail++; $display("FAIL ok_pc: got %h expected 42", bus.Pc_F); end
    n_cmp++; if (bus.GHR_f !== 4'b0111) begin n_fail++; $display("FAIL ok_ghr: got %b expected 0111", bus.GHR_f); end
    n_cmp++; if (bus.branch_cnt !== e_bc || bus.mispred_cnt !== e_mc) begin n_fail++; $display("FAIL ok_cnt: got %h/%h expected %h/%h", bus.branch_cnt, bus.mispred_cnt, e_bc, e_mc); end
  endtask

  task automatic test_wrap();
    drive(0, 6'd0, '0, 0, 1, 0, 1, 8'hFE, '0, 4'b0000);
    pop_exp();
    n_cmp++; if (bus.Pc_F !== 8'hFF) begin n_fail++; $display("FAIL wrap_setup: got %h expected ff", bus.Pc_F); end
    drive(0, 6'd4, 8'h01, 1, 0, 0, 0, '0, '0, '0);
    pop_exp();
    n_cmp++; if (bus.Pc_F !== 8'h01) begin n_fail++; $display("FAIL wrap_pc: got %h expected 01", bus.Pc_F); end
    drive(0, 6'd0, '0, 0, 1, 1, 0, 8'hF0, 8'h20, 4'b0000);
    pop_exp();
    n_cmp++; if (bus.Pc_F !== 8'h11) begin n_fail++; $display("FAIL wrap_redirect: got %h expected 11", bus.Pc_F); end
  endtask

  task automatic test_random();
    logic [5:0] opc;
    logic       res;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0: opc = 6'd4;
        1: opc = 6'd5;
        default: opc = 6'($urandom_range(0, 63));
      endcase
      res = ($urandom_range(0, 2) == 0);
      drive($urandom_range(0, 3) == 0, opc, 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), res, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
      pop_exp();
      n_cmp++;
      if (obs_flush !== e_fl || bus.Pc_F !== e_pc || bus.GHR_f !== e_ghr ||
          bus.branch_cnt !== e_bc || bus.mispred_cnt !== e_mc) begin
        n_fail++;
        $display("FAIL rand[%0d]: got fl %b pc %h ghr %h bc %h mc %h expected fl %b pc %h ghr %h bc %h mc %h",
                 i, obs_flush, bus.Pc_F, bus.GHR_f, bus.branch_cnt, bus.mispred_cnt,
                 e_fl, e_pc, e_ghr, e_bc, e_mc);
      end
    end
  endtask

  task automatic test_saturation();
    while (m_mc != 16'hFFFF) begin
      drive(0, 6'd0, '0, 0, 1, 0, 1, 8'h00, '0, '0);
      pop_exp();
    end
    n_cmp++; if (bus.mispred_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach: got %h expected ffff", bus.mispred_cnt); end
    drive(1, 6'd0, '0, 0, 1, 0, 1, 8'h00, '0, '0);
    pop_exp();
    n_cmp++; if (bus.mispred_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_mc_hold: got %h expected ffff", bus.mispred_cnt); end
    n_cmp++; if (bus.branch_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_bc_hold: got %h expected ffff", bus.branch_cnt); end
  endtask

  task automatic test_async_reset();
    drive(0, 6'd0, '0, 0, 0, 0, 0, '0, '0, '0);
    pop_exp();
    // Mispredict under stall pending, then reset lands between edges.
    bus.stall_F = 1'b1; bus.resolve_E = 1'b1; bus.actual_taken_E = 1'b1;
    bus.pred_taken_E = 1'b0; bus.pc_E = 8'h50; bus.imm_E = 8'h07; bus.ghr_E = 4'hF;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (bus.Pc_F !== 8'h00 || bus.GHR_f !== 4'h0 || bus.branch_cnt !== 16'h0 || bus.mispred_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL async_rst: got pc %h ghr %h bc %h mc %h expected all 0", bus.Pc_F, bus.GHR_f, bus.branch_cnt, bus.mispred_cnt);
    end
    @(posedge clk);
    #1;
    n_cmp++; if (bus.Pc_F !== 8'h00 || bus.mispred_cnt !== 16'h0) begin n_fail++; $display("FAIL async_hold: got pc %h mc %h expected 00 0", bus.Pc_F, bus.mispred_cnt); end
    idle_inputs();
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.Pc_F !== 8'h00) begin n_fail++; $display("FAIL post_rst_pc: got %h expected 00", bus.Pc_F); end
    @(posedge clk);
    #1;
    m_pc = 8'h01;
    n_cmp++; if (bus.Pc_F !== 8'h01) begin n_fail++; $display("FAIL post_rst_step: got %h expected 01", bus.Pc_F); end
    drive(0, 6'd4, 8'h02, 1, 0, 0, 0, '0, '0, '0);
    pop_exp();
    n_cmp++; if (bus.Pc_F !== 8'h04 || bus.GHR_f !== 4'b0001) begin n_fail++; $display("FAIL post_rst_br: got pc %h ghr %b expected 04 0001", bus.Pc_F, bus.GHR_f); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_sequential();
    test_predicted_branch();
    test_stall();
    test_mispredict_stall();
    test_correct_resolve();
    test_wrap();
    test_random();
    test_saturation();
    test_async_reset();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
